// File: rtl/hdc_result_monitor.sv
// hdc_result_monitor: synthesizable result sink and self-test monitor for hdc_sensor_fusion.
// Optional LFSR backpressure on dout_ready is enabled with `define HDC_RAND_READY_EN.
module hdc_result_monitor #(
    parameter int NUM_ENTRY = 20,
    parameter int TS_DEPTH  = 4,
    parameter int CYC_W     = 32,
    localparam int ED_W = $clog2(NUM_ENTRY + 1),
    localparam int NF_W = $clog2(2 * NUM_ENTRY + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 fin_valid,
    input  logic                 fin_ready,
    input  logic                 dout_valid,
    output logic                 dout_ready,
    input  logic                 valence,
    input  logic                 arousal,
    input  logic [NUM_ENTRY-1:0] exp_valence,
    input  logic [NUM_ENTRY-1:0] exp_arousal,
    output logic [ED_W-1:0]      entries_done,
    output logic [NF_W-1:0]      num_fail,
    output logic [CYC_W-1:0]     total_latency,
    output logic [CYC_W-1:0]     max_latency,
    output logic                 done,
    output logic                 err_overflow,
    output logic                 err_underflow
);

    localparam int PTR_W = (TS_DEPTH > 1) ? $clog2(TS_DEPTH) : 1;
    localparam int OCC_W = $clog2(TS_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_next;
    logic             run_start, run;
    logic             push, pop, push_ok, pop_ok;
    logic             fifo_full, fifo_empty;
    logic             val_miss, aro_miss;
    logic             ready_next;
    logic [CYC_W-1:0] cycle, latency;
    logic [CYC_W-1:0] ts_mem [TS_DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [OCC_W-1:0] occ;

    always_comb begin
        state_next = state;
        run_start  = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_next = RUN;
                    run_start  = 1'b1;
                end
            end
            RUN: begin
                if (pop && entries_done == ED_W'(NUM_ENTRY - 1)) state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign run        = (state == RUN);
    assign done       = (state == DONE);
    assign push       = run & fin_valid & fin_ready;
    assign pop        = run & dout_valid & dout_ready;
    assign fifo_full  = (occ == OCC_W'(TS_DEPTH));
    assign fifo_empty = (occ == '0);
    // A pop in the same cycle frees the slot, so a push on a full FIFO still lands.
    assign push_ok    = push & (~fifo_full | pop);
    assign pop_ok     = pop & ~fifo_empty;
    assign latency    = cycle - ts_mem[rd_ptr];
    assign val_miss   = valence ^ exp_valence[entries_done];
    assign aro_miss   = arousal ^ exp_arousal[entries_done];

`ifdef HDC_RAND_READY_EN
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    logic [15:0] lfsr;
    logic [3:0]  wait_cnt, wait_next;

    // Ready is high exactly when the reloaded/decremented wait count is zero.
    always_comb begin
        wait_next = wait_cnt;
        if (run_start) begin
            wait_next = LFSR_SEED[3:0];
        end else if (run) begin
            if (pop) wait_next = lfsr[3:0];
            else if (wait_cnt != 4'd0) wait_next = wait_cnt - 4'd1;
        end
        ready_next = (state_next == RUN) && (wait_next == 4'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr     <= LFSR_SEED;
            wait_cnt <= 4'd0;
        end else begin
            wait_cnt <= wait_next;
            if (run_start) lfsr <= LFSR_SEED;
            else if (run)  lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
        end
    end
`else
    assign ready_next = (state_next == RUN);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            dout_ready    <= 1'b0;
            cycle         <= '0;
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            occ           <= '0;
            entries_done  <= '0;
            num_fail      <= '0;
            total_latency <= '0;
            max_latency   <= '0;
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            state      <= state_next;
            dout_ready <= ready_next;
            if (run_start) begin
                cycle         <= '0;
                rd_ptr        <= '0;
                wr_ptr        <= '0;
                occ           <= '0;
                entries_done  <= '0;
                num_fail      <= '0;
                total_latency <= '0;
                max_latency   <= '0;
                err_overflow  <= 1'b0;
                err_underflow <= 1'b0;
            end else if (run) begin
                cycle <= cycle + CYC_W'(1);
                if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
                occ <= occ + OCC_W'(push_ok) - OCC_W'(pop_ok);
                if (push && fifo_full && !pop) err_overflow <= 1'b1;
                if (pop) begin
                    entries_done <= entries_done + ED_W'(1);
                    num_fail     <= num_fail + NF_W'(val_miss) + NF_W'(aro_miss);
                    if (fifo_empty) begin
                        err_underflow <= 1'b1;
                    end else begin
                        total_latency <= total_latency + latency;
                        if (latency > max_latency) max_latency <= latency;
                    end
                end
            end
        end
    end

    // Timestamp storage is pure data and needs no reset.
    always_ff @(posedge clk) begin
        if (push_ok) ts_mem[wr_ptr] <= cycle;
    end

endmodule
